// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: default widths, the
// RUN/FLUSH state encoding and the {addr, data} store-buffer record.
package mem_pkg;

  localparam int DW_DEFAULT       = 16;
  localparam int AW_DEFAULT       = 16;
  localparam int SB_DEPTH_DEFAULT = 4;

  // Loads forward from the buffer on a partial (low nibble) address match.
  localparam int FWD_BITS = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [AW_DEFAULT-1:0] addr;
    logic [DW_DEFAULT-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_access_unit_store_fifo.sv
// Circular store buffer with wrapping head/tail pointers, exposing every
// slot and its occupancy so the load path can search for forwarding hits.
module store_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [W-1:0]                push_data,
  input  logic                        pop,
  output logic [W-1:0]                head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [$clog2(DEPTH)-1:0]    head_ptr,
  output logic [DEPTH-1:0][W-1:0]     entries,
  output logic [DEPTH-1:0]            valid
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] slots;
  logic [PW-1:0]           tail_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PW'(1);
      if (do_pop)  head_ptr <= head_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: occupancy is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) slots[tail_ptr] <= push_data;
  end

  assign head    = slots[head_ptr];
  assign entries = slots;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);

  always_comb begin
    logic [PW-1:0] age;
    valid = '0;
    age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PW'(i) - head_ptr;
      valid[i] = ((PW+1)'(age) < count);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-port data memory: stores are posted
// into a FIFO buffer and drained in idle slots, loads own the port and
// forward from the youngest matching buffered store.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int AW       = AW_DEFAULT,
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  input  logic          flush_req,
  output logic          flush_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_data_out
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int EW = AW + DW;

  state_t                     state, state_next;
  logic                       load_acc, store_acc, drain;
  logic [EW-1:0]              sb_head;
  logic                       sb_full, sb_empty;
  logic [PW:0]                sb_count;
  logic [PW-1:0]              sb_head_ptr;
  logic [SB_DEPTH-1:0][EW-1:0] sb_entries;
  logic [SB_DEPTH-1:0]        sb_valid;
  logic                       fwd_hit;
  logic [DW-1:0]              fwd_data;
  logic [PW-1:0]              idx;

  // Gating with rst_n keeps the memory port quiet while reset is held.
  assign req_ready = rst_n && (state == RUN) && !sb_full;
  assign load_acc  = req_valid && req_ready && !req_write;
  assign store_acc = req_valid && req_ready && req_write;
  assign drain     = !sb_empty && !load_acc;

  store_fifo #(
    .W     (EW),
    .DEPTH (SB_DEPTH)
  ) u_store_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (store_acc),
    .push_data ({req_addr, req_wdata}),
    .pop       (drain),
    .head      (sb_head),
    .full      (sb_full),
    .empty     (sb_empty),
    .count     (sb_count),
    .head_ptr  (sb_head_ptr),
    .entries   (sb_entries),
    .valid     (sb_valid)
  );

  assign mem_read    = load_acc;
  assign mem_write   = drain;
  assign mem_addr    = load_acc ? req_addr : (drain ? sb_head[DW +: AW] : '0);
  assign mem_data_in = drain ? sb_head[DW-1:0] : '0;

  // Walk oldest to youngest so the last hit (youngest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = sb_head_ptr + PW'(k);
      if (sb_valid[idx] && (sb_entries[idx][DW +: FWD_BITS] == req_addr[FWD_BITS-1:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_entries[idx][DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= load_acc;
      if (load_acc) rsp_data <= fwd_hit ? fwd_data : mem_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // In FLUSH every cycle drains, so one entry left means empty after this edge.
  always_comb begin
    state_next = state;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        if (flush_req) state_next = FLUSH;
      end
      FLUSH: begin
        if (sb_count <= (PW+1)'(1)) begin
          state_next = RUN;
          flush_done = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DW, default 16: data width.
REQ-002 SHALL have parameter AW, default 16: address width.
REQ-003 SHALL have parameter SB_DEPTH, default 4: store-buffer entries, power of two, at least 2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have these request ports:
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1=store, 0=load.
- req_addr  in  AW  word address.
- req_wdata  in  DW  store data.
REQ-006 SHALL have these response ports:
- rsp_valid  out  1  load data valid for one cycle.
- rsp_data  out  DW  load result.
REQ-007 SHALL have these flush ports:
- flush_req  in  1  drain request, one-cycle pulse.
- flush_done  out  1  one-cycle pulse when the buffer is empty after a flush.
REQ-008 SHALL have these data-memory ports:
- mem_addr  out  AW  to the data-memory addr input.
- mem_data_in  out  DW  write data to the memory.
- mem_write  out  1  to MemWrite.
- mem_read  out  1  to MemRead.
- mem_data_out  in  DW  combinational read data from the memory.

Function
REQ-009 SHALL accept a request on any rising edge where req_valid && req_ready.
REQ-010 SHALL hold req_ready = (state==RUN) && !sb_full, with no dependency on req_write.
REQ-011 SHALL write an accepted store into the tail of the SB_DEPTH-entry FIFO store buffer as {addr, data}.
- No memory access occurs in the acceptance cycle.
REQ-012 SHALL give an accepted load the memory port in its acceptance cycle: mem_read=1, mem_addr=req_addr, mem_write=0.
REQ-013 SHALL forward a load from the buffer when req_addr[3:0] matches a valid entry's addr[3:0].
- The youngest match wins.
- Otherwise the unit captures mem_data_out.
REQ-014 SHALL register the load response: rsp_valid=1 and rsp_data valid exactly one cycle after acceptance, for one cycle.
- There is no response backpressure.
REQ-015 SHALL drain in any cycle where the buffer is non-empty and no load is accepted: mem_write=1, mem_addr=head.addr, mem_data_in=head.data.
- The head pops on that edge.
REQ-016 SHALL support a simultaneous store enqueue and head drain in one cycle, leaving the count unchanged.
REQ-017 SHALL drive mem_read=0 and mem_write=0 in idle cycles, and SHALL never assert both in one cycle.
REQ-018 SHALL hold mem_addr and mem_data_in at 0 when the port is idle.
REQ-019 SHALL implement an FSM with states RUN and FLUSH:
- RUN->FLUSH on flush_req.
- FLUSH->RUN when the buffer is empty.
- flush_done=1 on the cycle of the FLUSH->RUN transition.
REQ-020 SHALL behave as follows on flush_req while the buffer is already empty: enter FLUSH for one cycle, then pulse flush_done.
REQ-021 SHALL deassert req_ready in FLUSH and drain one entry per cycle.
REQ-022 SHALL ignore flush_req while in FLUSH.
REQ-023 SHALL keep head/tail pointers as log2(SB_DEPTH)-bit values that wrap modulo SB_DEPTH, plus a count of width log2(SB_DEPTH)+1.
- Full is count==SB_DEPTH; empty is count==0.
REQ-024 SHALL preserve program order: loads see all earlier stores (buffered or drained), and stores reach memory in acceptance order.

Reset
REQ-025 SHALL, while rst_n=0, immediately force:
- rsp_valid=0, rsp_data=0, flush_done=0.
- mem_write=0, mem_read=0, mem_addr=0, mem_data_in=0.
- count=0, pointers=0, state=RUN.
REQ-026 SHALL discard buffered stores on reset mid-operation, never writing them to memory.
REQ-027 SHALL drive req_ready=1 in the first cycle after rst_n rises.

Structure
REQ-028 SHALL place DW, AW, SB_DEPTH defaults, the RUN/FLUSH state encoding and the store-entry record type in shared package mem_pkg.
REQ-029 SHALL implement the buffer as sub-module store_fifo, which exposes:
- push, pop, head, full, empty.
- Parallel entry/valid vectors for forwarding compare.

Verification
REQ-030 SHALL cover a load on an empty buffer: memory word 5=0x1234; load addr 5 -> mem_read=1 with mem_addr=5 that cycle; rsp_valid next cycle with rsp_data=0x1234.
REQ-031 SHALL cover forwarding: store 0x00AA to addr 3, store 0x00BB to addr 3, load addr 3 before drain -> rsp_data=0x00BB and mem_read still asserted.
REQ-032 SHALL cover alias forwarding: store 0xBEEF to addr 0x0013, load addr 0x0003 -> rsp_data=0xBEEF.
REQ-033 SHALL cover full and drain ordering: 4 back-to-back stores to addrs 1..4 with load traffic held off -> drained in order 1,2,3,4; req_ready low whenever count==4; no 5th acceptance while full.
REQ-034 SHALL cover flush: 3 buffered stores, flush_req -> req_ready=0, 3 consecutive mem_write cycles, flush_done pulse on the third, req_ready=1 next cycle.
REQ-035 SHALL cover reset mid-operation: 2 buffered stores, rst_n low for 1 cycle -> no mem_write ever issued for them; all outputs 0 during reset; req_ready=1 after reset.
